relu_backward: RTL and testbench

- Backward-pass counterpart of the forward ReLU stage in the CNN datapath.
- Takes the forward pre-activation vector x and the upstream gradient vector grad_in, both packed, with NOFINPUTS elements of DATA_WIDTH bits each.
- Produces grad_out: grad_in passed through where x > 0, zeroed elsewhere.
- Processes one element per clock under a start/over handshake, and reports how many gradients were blocked.

---
 rtl/relu_backward.sv | 94 +++++++++
 tb/tb_relu_backward.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/relu_backward.sv
// relu_backward: backward pass of the ReLU stage.
// After each start, the inputs are snapshotted, then one element is handled per clock.
// grad_out[i] = grad_in[i] if x[i] > 0, else 0; zero_count counts the blocked gradients.
module relu_backward #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned NOFINPUTS  = 7,
  parameter int unsigned CNT_W      = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NOFINPUTS*DATA_WIDTH-1:0] x,
  input  logic [NOFINPUTS*DATA_WIDTH-1:0] grad_in,
  input  logic                            start_flag,
  output logic [NOFINPUTS*DATA_WIDTH-1:0] grad_out,
  output logic                            over_flag,
  output logic                            busy,
  output logic [CNT_W-1:0]                zero_count
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e                state;
  logic [CNT_W-1:0]      index;
  logic [DATA_WIDTH-1:0] x_snap [NOFINPUTS];
  logic [DATA_WIDTH-1:0] g_snap [NOFINPUTS];

  logic [DATA_WIDTH-1:0] cur_x;
  logic [DATA_WIDTH-1:0] cur_g;
  logic                  cur_pass;

  // Select the snapshot element addressed by index; x > 0 means sign clear and nonzero.
  always_comb begin
    cur_x = '0;
    cur_g = '0;
    for (int i = 0; i < NOFINPUTS; i++) begin
      if (index == CNT_W'(i)) begin
        cur_x = x_snap[i];
        cur_g = g_snap[i];
      end
    end
    cur_pass = ~cur_x[DATA_WIDTH-1] & (|cur_x);
  end

  // Control FSM, snapshot capture and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= StIdle;
      index      <= '0;
      grad_out   <= '0;
      over_flag  <= 1'b0;
      busy       <= 1'b0;
      zero_count <= '0;
      for (int i = 0; i < NOFINPUTS; i++) begin
        x_snap[i] <= '0;
        g_snap[i] <= '0;
      end
    end else begin
      unique case (state)
        StIdle, StDone: begin
          if (start_flag) begin
            for (int i = 0; i < NOFINPUTS; i++) begin
              x_snap[i] <= x[DATA_WIDTH*i +: DATA_WIDTH];
              g_snap[i] <= grad_in[DATA_WIDTH*i +: DATA_WIDTH];
            end
            grad_out   <= '0;
            zero_count <= '0;
            index      <= '0;
            busy       <= 1'b1;
            over_flag  <= 1'b0;
            state      <= StRun;
          end
        end
        StRun: begin
          for (int i = 0; i < NOFINPUTS; i++) begin
            if (index == CNT_W'(i)) begin
              grad_out[DATA_WIDTH*i +: DATA_WIDTH] <= cur_pass ? cur_g : '0;
            end
          end
          if (!cur_pass) begin
            zero_count <= zero_count + CNT_W'(1);
          end
          index <= index + CNT_W'(1);
          if (index == CNT_W'(NOFINPUTS - 1)) begin
            state     <= StDone;
            over_flag <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_relu_backward.sv
// Directed self-checking bench for relu_backward.
module tb_relu_backward;

  localparam int DW = 16;
  localparam int N  = 7;
  localparam int CW = 8;

  logic            clk;
  logic            rst;
  logic [N*DW-1:0] x;
  logic [N*DW-1:0] grad_in;
  logic            start_flag;
  logic [N*DW-1:0] grad_out;
  logic            over_flag;
  logic            busy;
  logic [CW-1:0]   zero_count;

  int n_checks = 0;
  int n_fail   = 0;

  relu_backward #(
    .DATA_WIDTH(DW),
    .NOFINPUTS (N),
    .CNT_W     (CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .x         (x),
    .grad_in   (grad_in),
    .start_flag(start_flag),
    .grad_out  (grad_out),
    .over_flag (over_flag),
    .busy      (busy),
    .zero_count(zero_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N*DW-1:0] pack_vec(input int v [N]);
    logic [N*DW-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) r[DW*i +: DW] = v[i][DW-1:0];
    return r;
  endfunction

  // Advance one clock; sample 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present vectors with a 1-cycle start pulse; returns just after the capture edge E0.
  task automatic start_pass(input logic [N*DW-1:0] xv, input logic [N*DW-1:0] gv);
    x          = xv;
    grad_in    = gv;
    start_flag = 1'b1;
    step();
    start_flag = 1'b0;
  endtask

  int xa [N];
  int ga [N];
  int ea [N];
  logic [N*DW-1:0] basic_x, basic_g, basic_exp;
  logic [N*DW-1:0] ones_x, seq_g;
  int busy_cycles;

  initial begin
    xa = '{5, -3, 0, 1, -32768, 32767, -1};
    ga = '{10, 20, 30, 40, 50, 60, 70};
    ea = '{10, 0, 0, 40, 0, 60, 0};
    basic_x   = pack_vec(xa);
    basic_g   = pack_vec(ga);
    basic_exp = pack_vec(ea);
    xa = '{1, 1, 1, 1, 1, 1, 1};
    ga = '{1, 2, 3, 4, 5, 6, 7};
    ones_x = pack_vec(xa);
    seq_g  = pack_vec(ga);

    // Reset with noisy inputs and start held high.
    rst        = 1'b1;
    start_flag = 1'b1;
    for (int i = 0; i < N; i++) begin
      x[DW*i +: DW]       = DW'($urandom);
      grad_in[DW*i +: DW] = DW'($urandom);
    end
    step();
    step();
    check_eq("rst_grad_out", 128'(grad_out), 128'(0));
    check_eq("rst_over", 128'(over_flag), 128'(0));
    check_eq("rst_busy", 128'(busy), 128'(0));
    check_eq("rst_zero_count", 128'(zero_count), 128'(0));
    rst        = 1'b0;
    start_flag = 1'b0;
    step();
    check_eq("idle_busy", 128'(busy), 128'(0));

    // Basic pass: busy for exactly 7 cycles, over after E7.
    start_pass(basic_x, basic_g);
    check_eq("basic_e0_over", 128'(over_flag), 128'(0));
    busy_cycles = int'(busy);
    for (int k = 1; k < N; k++) begin
      step();
      busy_cycles += int'(busy);
      check_eq("basic_over_early", 128'(over_flag), 128'(0));
    end
    step();
    check_eq("basic_busy_cycles", 128'(busy_cycles), 128'(N));
    check_eq("basic_over", 128'(over_flag), 128'(1));
    check_eq("basic_busy_end", 128'(busy), 128'(0));
    check_eq("basic_grad_out", 128'(grad_out), 128'(basic_exp));
    check_eq("basic_zero_count", 128'(zero_count), 128'(4));

    // Snapshot isolation: inputs scrambled right after capture.
    start_pass(basic_x, basic_g);
    check_eq("snap_e0_over", 128'(over_flag), 128'(0));
    x       = {N{16'hFFFF}};
    grad_in = {N{16'h7FFF}};
    repeat (N) step();
    check_eq("snap_over", 128'(over_flag), 128'(1));
    check_eq("snap_grad_out", 128'(grad_out), 128'(basic_exp));
    check_eq("snap_zero_count", 128'(zero_count), 128'(4));

    // Start pulsed while element 3 is being processed must be ignored.
    start_pass(basic_x, basic_g);
    repeat (3) step();
    start_flag = 1'b1;
    step();
    start_flag = 1'b0;
    repeat (3) step();
    check_eq("ign_over", 128'(over_flag), 128'(1));
    check_eq("ign_grad_out", 128'(grad_out), 128'(basic_exp));
    check_eq("ign_zero_count", 128'(zero_count), 128'(4));
    repeat (3) step();
    check_eq("ign_over_hold", 128'(over_flag), 128'(1));
    check_eq("ign_busy_hold", 128'(busy), 128'(0));
    check_eq("ign_grad_hold", 128'(grad_out), 128'(basic_exp));

    // Restart from DONE.
    start_pass(ones_x, seq_g);
    check_eq("rs_e0_over", 128'(over_flag), 128'(0));
    check_eq("rs_e0_busy", 128'(busy), 128'(1));
    check_eq("rs_e0_grad_cleared", 128'(grad_out), 128'(0));
    repeat (N) step();
    check_eq("rs_over", 128'(over_flag), 128'(1));
    check_eq("rs_grad_out", 128'(grad_out), 128'(seq_g));
    check_eq("rs_zero_count", 128'(zero_count), 128'(0));

    // Reset mid-run after element 3 is written (edge E4).
    start_pass(basic_x, basic_g);
    repeat (4) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_eq("mid_grad_out", 128'(grad_out), 128'(0));
    check_eq("mid_over", 128'(over_flag), 128'(0));
    check_eq("mid_busy", 128'(busy), 128'(0));
    check_eq("mid_zero_count", 128'(zero_count), 128'(0));
    repeat (3) step();
    check_eq("mid_idle_busy", 128'(busy), 128'(0));
    check_eq("mid_idle_over", 128'(over_flag), 128'(0));
    start_pass(ones_x, seq_g);
    repeat (N - 1) step();
    check_eq("mid_pass_over_early", 128'(over_flag), 128'(0));
    step();
    check_eq("mid_pass_over", 128'(over_flag), 128'(1));
    check_eq("mid_pass_grad_out", 128'(grad_out), 128'(seq_g));
    check_eq("mid_pass_zero_count", 128'(zero_count), 128'(0));

    // Back-to-back passes with start held high: one DONE cycle in between.
    x          = basic_x;
    grad_in    = basic_g;
    start_flag = 1'b1;
    step();
    repeat (N) step();
    check_eq("b2b_over_done", 128'(over_flag), 128'(1));
    check_eq("b2b_grad_out", 128'(grad_out), 128'(basic_exp));
    step();
    check_eq("b2b_recapture_busy", 128'(busy), 128'(1));
    check_eq("b2b_recapture_over", 128'(over_flag), 128'(0));
    start_flag = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
